// File: rtl/pipe_control.sv
// Pipelined RV32I control: ID decode, ID/EX -> EX/MEM -> MEM/WB control bundle,
// load-use / RAW stall, EX forwarding selects and EX branch resolution with flush.
module pipe_control #(
    parameter int XLEN   = 32,
    parameter int RA_W   = 5,
    parameter int FWD_EN = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     instr,
    input  logic            id_valid,
    input  logic            BrEq,
    input  logic            BrLT,
    output logic            pc_en,
    output logic            ifid_en,
    output logic            ifid_flush,
    output logic [2:0]      ImmSel,
    output logic            illegal,
    output logic            ALUsrc1,
    output logic            ALUsrc2,
    output logic [3:0]      AluSEL,
    output logic            BrUn,
    output logic [1:0]      fwdA,
    output logic [1:0]      fwdB,
    output logic            PCSel,
    output logic            MemRw,
    output logic [2:0]      ldU,
    output logic            RegWEn,
    output logic [1:0]      WBSel,
    output logic [RA_W-1:0] rd_wb
);

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    typedef struct packed {
        logic            valid;
        logic            wen;
        logic            mrw;
        logic            load;
        logic            br;
        logic            jmp;
        logic [2:0]      f3;
        logic            src1;
        logic            src2;
        logic [3:0]      alu;
        logic            brun;
        logic [1:0]      wbsel;
        logic [RA_W-1:0] rd;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
    } idex_t;

    typedef struct packed {
        logic            wen;
        logic            mrw;
        logic [2:0]      ldu;
        logic [1:0]      wbsel;
        logic [RA_W-1:0] rd;
    } exmem_t;

    typedef struct packed {
        logic            wen;
        logic [1:0]      wbsel;
        logic [RA_W-1:0] rd;
    } memwb_t;

    idex_t  dec, idex;
    exmem_t exmem;
    memwb_t memwb;
    logic   legal, use1, use2, id_ok, stall, taken, brc;
    logic   unused_bits;

    // Decode width is fixed at 32 bits; these fields never steer control.
    assign unused_bits = ^{instr[31], instr[29:25]} ^ (XLEN != 32);

    // Unused source fields are zeroed so they can never match a producer.
    always_comb begin
        dec       = '0;
        dec.valid = 1'b1;
        dec.wbsel = 2'b01;
        dec.f3    = instr[14:12];
        legal     = 1'b1;
        use1      = 1'b0;
        use2      = 1'b0;
        ImmSel    = 3'b000;
        case (instr[6:0])
            OP_LUI:   begin dec.wen = 1'b1; dec.src2 = 1'b1; dec.alu = 4'b1111; ImmSel = 3'b011; end
            OP_AUIPC: begin dec.wen = 1'b1; dec.src1 = 1'b1; dec.src2 = 1'b1; ImmSel = 3'b011; end
            OP_JAL:   begin dec.wen = 1'b1; dec.jmp = 1'b1; dec.src1 = 1'b1; dec.src2 = 1'b1;
                            dec.wbsel = 2'b10; ImmSel = 3'b100; end
            OP_JALR:  begin dec.wen = 1'b1; dec.jmp = 1'b1; dec.src2 = 1'b1; dec.wbsel = 2'b10; use1 = 1'b1; end
            OP_BR:    begin dec.br = 1'b1; dec.src1 = 1'b1; dec.src2 = 1'b1; dec.brun = instr[13];
                            use1 = 1'b1; use2 = 1'b1; ImmSel = 3'b010; end
            OP_LD:    begin dec.wen = 1'b1; dec.load = 1'b1; dec.src2 = 1'b1; dec.wbsel = 2'b00; use1 = 1'b1; end
            OP_ST:    begin dec.mrw = 1'b1; dec.src2 = 1'b1; use1 = 1'b1; use2 = 1'b1; ImmSel = 3'b001; end
            OP_IMM:   begin dec.wen = 1'b1; dec.src2 = 1'b1; use1 = 1'b1;
                            dec.alu = (instr[13:12] == 2'b01) ? {instr[30], instr[14:12]} : {1'b0, instr[14:12]}; end
            OP_REG:   begin dec.wen = 1'b1; use1 = 1'b1; use2 = 1'b1; dec.alu = {instr[30], instr[14:12]}; end
            default:  legal = 1'b0;
        endcase
        dec.rd  = dec.wen ? instr[7 +: RA_W] : '0;
        dec.rs1 = use1 ? instr[15 +: RA_W] : '0;
        dec.rs2 = use2 ? instr[20 +: RA_W] : '0;
    end

    assign illegal = id_valid && !legal;
    assign id_ok   = id_valid && legal;

    function automatic logic hit(input logic wen, input logic [RA_W-1:0] rd,
                                 input logic [RA_W-1:0] rs1, input logic [RA_W-1:0] rs2);
        return wen && (rd != '0) && ((rd == rs1) || (rd == rs2));
    endfunction

    function automatic logic [1:0] fsel(input logic [RA_W-1:0] rs, input exmem_t m, input memwb_t w);
        if (rs == '0)                 return 2'b00;
        else if (m.wen && m.rd == rs) return 2'b01;
        else if (w.wen && w.rd == rs) return 2'b10;
        else                          return 2'b00;
    endfunction

    always_comb begin
        stall = 1'b0;
        if (id_ok) begin
            if (FWD_EN != 0)
                stall = idex.load && hit(idex.wen, idex.rd, dec.rs1, dec.rs2);
            else
                stall = hit(idex.wen, idex.rd, dec.rs1, dec.rs2)
                      | hit(exmem.wen, exmem.rd, dec.rs1, dec.rs2)
                      | hit(memwb.wen, memwb.rd, dec.rs1, dec.rs2);
        end
    end

    always_comb begin
        case (idex.f3)
            3'b000:         brc = BrEq;
            3'b001:         brc = !BrEq;
            3'b100, 3'b110: brc = BrLT;
            3'b101, 3'b111: brc = !BrLT;
            default:        brc = 1'b0;
        endcase
    end

    // A taken branch/jump flushes the front end and wins over any stall.
    assign taken      = idex.jmp || (idex.br && brc);
    assign PCSel      = taken;
    assign ifid_flush = taken;
    assign pc_en      = !stall || taken;
    assign ifid_en    = !stall || taken;

    assign fwdA    = (FWD_EN != 0) ? fsel(idex.rs1, exmem, memwb) : 2'b00;
    assign fwdB    = (FWD_EN != 0) ? fsel(idex.rs2, exmem, memwb) : 2'b00;
    assign ALUsrc1 = idex.src1;
    assign ALUsrc2 = idex.src2;
    assign AluSEL  = idex.alu;
    assign BrUn    = idex.brun;
    assign MemRw   = exmem.mrw;
    assign ldU     = exmem.ldu;
    assign RegWEn  = memwb.wen;
    assign WBSel   = memwb.wbsel;
    assign rd_wb   = memwb.rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex        <= '0;
            idex.wbsel  <= 2'b01;
            exmem       <= '0;
            exmem.wbsel <= 2'b01;
            memwb       <= '0;
            memwb.wbsel <= 2'b01;
        end else begin
            if (!id_ok || stall || taken) begin
                idex       <= '0;
                idex.wbsel <= 2'b01;
            end else begin
                idex <= dec;
            end
            exmem.wen   <= idex.wen;
            exmem.mrw   <= idex.mrw;
            exmem.ldu   <= idex.load ? idex.f3 : 3'b000;
            exmem.wbsel <= idex.wbsel;
            exmem.rd    <= idex.rd;
            memwb.wen   <= exmem.wen;
            memwb.wbsel <= exmem.wbsel;
            memwb.rd    <= exmem.rd;
        end
    end

endmodule
